// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the uart_ctl transmit scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    localparam logic [15:0] DEFAULT_DIV = 16'd26;
    localparam logic [1:0]  CTL_TX_IDLE = 2'b00;

    // uart_ctl reports its TX sub-state in the upper two bits of its state word.
    function automatic logic ctl_tx_idle(input logic [3:0] ctl_st);
        return (ctl_st[3:2] == CTL_TX_IDLE);
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational rotate-priority encoder: searches req from last+1, wrapping modulo N.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [$clog2(N)-1:0] gnt_id_o,
    output logic                 gnt_valid_o
);
    localparam int IDW = $clog2(N);

    logic [IDW-1:0] cand_s;
    logic           found_s;

    // Walk the requesters starting just after the previous winner; first hit wins.
    always_comb begin
        cand_s      = '0;
        found_s     = 1'b0;
        gnt_id_o    = '0;
        for (int k = 1; k <= N; k++) begin
            cand_s = IDW'((int'(last_i) + k) % N);
            if (!found_s && req_i[cand_s]) begin
                found_s  = 1'b1;
                gnt_id_o = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
        gnt_valid_o = found_s;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin packet scheduler in front of uart_ctl with between-packet divisor updates.
// Optional watchdog in WAIT is built when UART_TX_SCHED_TIMEOUT_EN is defined.
module uart_tx_sched #(
    parameter int          NUM_REQ        = 4,
    parameter logic [15:0] DEFAULT_DIV    = uart_sched_pkg::DEFAULT_DIV,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [128*NUM_REQ-1:0]     req_data,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    input  logic                       cfg_wr,
    input  logic [15:0]                cfg_divisor,
    output logic [15:0]                baud_divisor,
    input  logic [3:0]                 ctl_state,
    output logic [127:0]               tx_data,
    output logic                       data_valid,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] cur_id
);
    import uart_sched_pkg::*;

    localparam int                 IDW      = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0]     LAST_RST = IDW'(NUM_REQ-1);

    sched_state_t   state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] cur_id_q, cur_id_d;
    logic [127:0]   tx_data_q, tx_data_d;
    logic [15:0]    div_q, div_d;
    logic [15:0]    shadow_q, shadow_d;
    logic           cfg_pending_q, cfg_pending_d;

    logic           ctl_idle_s;
    logic           apply_s;
    logic           gnt_valid_s;
    logic [IDW-1:0] gnt_id_s;
    logic           timeout_s;
    logic           to_flag_s;

    assign ctl_idle_s = ctl_tx_idle(ctl_state);

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req_i       (req),
        .last_i      (last_q),
        .gnt_id_o    (gnt_id_s),
        .gnt_valid_o (gnt_valid_s)
    );

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        to_flag_q, to_flag_d;

    assign timeout_s = (cnt_q == (TIMEOUT_CYCLES - 32'd1));
    assign to_flag_s = to_flag_q;

    // Watchdog counter: zeroed while issuing so it reads 0 in the first WAIT cycle.
    always_comb begin
        cnt_d = cnt_q;
        case (state_q)
            ST_ISSUE: cnt_d = 32'd0;
            ST_WAIT:  cnt_d = cnt_q + 32'd1;
            default:  cnt_d = cnt_q;
        endcase
    end

    // Watchdog registers; the flag marks a DONE visit caused by a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 32'd0;
            to_flag_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            to_flag_q <= to_flag_d;
        end
    end
`else
    logic [31:0] unused_timeout_s;

    assign unused_timeout_s = TIMEOUT_CYCLES;
    assign timeout_s        = 1'b0;
    assign to_flag_s        = 1'b0;
`endif

    // Divisor shadow: a new write always wins over clearing the pending flag.
    always_comb begin
        apply_s = (state_q == ST_IDLE) && cfg_pending_q && ctl_idle_s;
        if (cfg_wr) begin
            shadow_d      = cfg_divisor;
            cfg_pending_d = 1'b1;
        end else if (apply_s) begin
            shadow_d      = shadow_q;
            cfg_pending_d = 1'b0;
        end else begin
            shadow_d      = shadow_q;
            cfg_pending_d = cfg_pending_q;
        end
        if (apply_s) begin
            div_d = shadow_q;
        end else begin
            div_d = div_q;
        end
    end

    // Scheduler next-state; a timeout reuses DONE so err and done share one retire cycle.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cur_id_d  = cur_id_q;
        tx_data_d = tx_data_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        to_flag_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (apply_s) begin
                    state_d = ST_IDLE;
                end else if (gnt_valid_s && ctl_idle_s) begin
                    cur_id_d  = gnt_id_s;
                    tx_data_d = req_data[{gnt_id_s, 7'd0} +: 128];
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    state_d = ST_DONE;
                end else if (timeout_s) begin
                    state_d = ST_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    to_flag_d = 1'b1;
`endif
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                last_d  = cur_id_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q        <= LAST_RST;
            cur_id_q      <= '0;
            tx_data_q     <= 128'd0;
            div_q         <= DEFAULT_DIV;
            shadow_q      <= DEFAULT_DIV;
            cfg_pending_q <= 1'b0;
        end else begin
            last_q        <= last_d;
            cur_id_q      <= cur_id_d;
            tx_data_q     <= tx_data_d;
            div_q         <= div_d;
            shadow_q      <= shadow_d;
            cfg_pending_q <= cfg_pending_d;
        end
    end

    // Outputs are register copies or decodes of the state register only.
    always_comb begin
        data_valid   = (state_q == ST_ISSUE);
        busy         = (state_q != ST_IDLE);
        tx_data      = tx_data_q;
        cur_id       = cur_id_q;
        baud_divisor = div_q;
        if (state_q == ST_DONE && !to_flag_s) begin
            done = ONE_HOT0 << cur_id_q;
        end else begin
            done = '0;
        end
        if (state_q == ST_DONE && to_flag_s) begin
            err = ONE_HOT0 << cur_id_q;
        end else begin
            err = '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed stimulus pushes expected events, a monitor checks them.
`timescale 1ns/1ps
module tb_uart_tx_sched;
    localparam int N      = 4;
    localparam int K_DV   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [128*N-1:0] req_data;
    logic [N-1:0]     done, err;
    logic             cfg_wr;
    logic [15:0]      cfg_divisor, baud_divisor;
    logic [3:0]       ctl_state;
    logic [127:0]     tx_data;
    logic             data_valid, tx_done, busy;
    logic [1:0]       cur_id;

    uart_tx_sched #(
        .NUM_REQ        (N),
        .DEFAULT_DIV    (16'd26),
        .TIMEOUT_CYCLES (32'd100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .done         (done),
        .err          (err),
        .cfg_wr       (cfg_wr),
        .cfg_divisor  (cfg_divisor),
        .baud_divisor (baud_divisor),
        .ctl_state    (ctl_state),
        .tx_data      (tx_data),
        .data_valid   (data_valid),
        .tx_done      (tx_done),
        .busy         (busy),
        .cur_id       (cur_id)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           kind;
        int           id;
        logic [N-1:0] mask;
        logic [127:0] data;
        longint       at;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] pkt_tbl[N];
    int           checks   = 0;
    int           failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int id, input longint at);
        exp_t e;
        e.kind = kind;
        e.id   = id;
        e.mask = 4'b0001 << id;
        e.data = pkt_tbl[id];
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every DUT event must match the oldest expectation.
    initial begin
        exp_t e;
        int   seen;
        forever begin
            @(negedge clk);
            if (rst_n && (data_valid || done != 4'b0000 || err != 4'b0000)) begin
                seen = data_valid ? K_DV : ((err != 4'b0000) ? K_ERR : K_DONE);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: dv=%0b done=%b err=%b at cycle %0d, none expected",
                             data_valid, done, err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", seen, e.kind);
                    chk("event_cycle", cyc, e.at);
                    if (e.kind == K_DV) begin
                        chk("dv_cur_id", cur_id, e.id);
                        chk("dv_tx_data", tx_data, e.data);
                    end else if (e.kind == K_DONE) begin
                        chk("done_mask", done, e.mask);
                        chk("done_err_quiet", err, 4'b0000);
                    end else begin
                        chk("err_mask", err, e.mask);
                        chk("err_done_quiet", done, 4'b0000);
                    end
                end
            end
        end
    end

    task automatic wait_dv(output longint d);
        d = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (data_valid) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) begin
            checks++;
            failures++;
            $display("FAIL dv_timeout: data_valid=0 for 60 cycles, expected a pulse");
        end
    endtask

    // Serve one packet: tx_done dly cycles after data_valid; returns the done cycle.
    task automatic serve(input int id, input int dly, output longint fin);
        longint d;
        wait_dv(d);
        repeat (dly) @(posedge clk);
        #1;
        tx_done = 1'b1;
        push_ev(K_DONE, id, d + dly + 1);
        @(posedge clk); #1;
        tx_done = 1'b0;
        fin = cyc;
        @(posedge clk); #1;
        req[id] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        longint d, fin;
        logic   dv_seen;
        rst_n       = 1'b0;
        req         = 4'b0000;
        cfg_wr      = 1'b0;
        cfg_divisor = 16'd0;
        ctl_state   = 4'b0000;
        tx_done     = 1'b0;
        pkt_tbl[0]  = 128'h0F0E0D0C0B0A09080706050403020100;
        pkt_tbl[1]  = 128'h11111111_C0DE0001_A5A5A5A5_00000001;
        pkt_tbl[2]  = 128'h22222222_C0DE0002_5A5A5A5A_00000002;
        pkt_tbl[3]  = 128'h33333333_C0DE0003_FFFF0000_00000003;
        for (int i = 0; i < N; i++) req_data[128*i +: 128] = pkt_tbl[i];

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_tx_data", tx_data, 128'd0);
        chk("rst_done", done, 4'b0000);
        chk("rst_err", err, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cur_id", cur_id, 2'd0);
        chk("rst_baud", baud_divisor, 16'd26);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single packet from requester 0
        @(posedge clk); #1;
        req = 4'b0001;
        push_ev(K_DV, 0, cyc + 1);
        serve(0, 5, fin);
        @(negedge clk);
        chk("busy_after_done", busy, 1'b0);
        chk("cur_id_after_done", cur_id, 2'd0);

        // Round-robin from reset: 0,1,2,3 (first gap is the 4-cycle minimum)
        do_reset();
        req = 4'b1111;
        push_ev(K_DV, 0, cyc + 1);
        for (int i = 0; i < 4; i++) begin
            serve(i, i + 1, fin);
            if (i < 3) push_ev(K_DV, i + 1, fin + 2);
        end
        @(posedge clk); #1;
        req = 4'b0101;
        push_ev(K_DV, 0, cyc + 1);
        serve(0, 2, fin);
        push_ev(K_DV, 2, fin + 2);
        serve(2, 2, fin);

        // Deferred divisor: written in WAIT, applied in IDLE, grant delayed a cycle
        @(posedge clk); #1;
        req = 4'b0010;
        push_ev(K_DV, 1, cyc + 1);
        wait_dv(d);
        @(posedge clk); #1;
        cfg_wr      = 1'b1;
        cfg_divisor = 16'd53;
        req[3]      = 1'b1;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        @(posedge clk); #1;
        tx_done = 1'b1;
        push_ev(K_DONE, 1, d + 4);
        @(negedge clk);
        chk("baud_in_wait", baud_divisor, 16'd26);
        @(posedge clk); #1;
        tx_done = 1'b0;
        @(negedge clk);
        chk("baud_in_done", baud_divisor, 16'd26);
        push_ev(K_DV, 3, d + 7);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("baud_applied", baud_divisor, 16'd53);
        serve(3, 2, fin);

        // Controller busy: no grant until ctl_state[3:2] returns to 0
        @(posedge clk); #1;
        ctl_state = 4'b0100;
        req       = 4'b0010;
        dv_seen   = 1'b0;
        repeat (3) begin @(negedge clk); if (data_valid) dv_seen = 1'b1; end
        ctl_state = 4'b1000;
        repeat (3) begin @(negedge clk); if (data_valid) dv_seen = 1'b1; end
        chk("no_dv_ctl_busy", dv_seen, 1'b0);
        @(posedge clk); #1;
        ctl_state = 4'b0011;
        push_ev(K_DV, 1, cyc + 1);
        serve(1, 2, fin);

        // Reset during WAIT with a pending divisor write
        @(posedge clk); #1;
        req = 4'b0100;
        push_ev(K_DV, 2, cyc + 1);
        wait_dv(d);
        @(posedge clk); #1;
        cfg_wr      = 1'b1;
        cfg_divisor = 16'd77;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        rst_n  = 1'b0;
        req    = 4'b0000;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_tx_data", tx_data, 128'd0);
        chk("midrst_cur_id", cur_id, 2'd0);
        chk("midrst_baud", baud_divisor, 16'd26);
        chk("midrst_done_err", {done, err}, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("baud_no_apply_after_rst", baud_divisor, 16'd26);
        @(posedge clk); #1;
        req = 4'b0101;
        push_ev(K_DV, 0, cyc + 1);
        serve(0, 2, fin);
        push_ev(K_DV, 2, fin + 2);
        serve(2, 2, fin);

        // tx_done outside WAIT (in IDLE and in ISSUE) must not complete a packet
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        req     = 4'b1000;
        push_ev(K_DV, 3, cyc + 1);
        wait_dv(d);
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tx_done = 1'b1;
        push_ev(K_DONE, 3, d + 5);
        @(posedge clk); #1;
        tx_done = 1'b0;
        @(posedge clk); #1;
        req = 4'b0000;

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Watchdog: err 100 cycles after WAIT entry, late tx_done ignored
        @(posedge clk); #1;
        req = 4'b0010;
        push_ev(K_DV, 1, cyc + 1);
        wait_dv(d);
        push_ev(K_ERR, 1, d + 101);
        repeat (101) @(posedge clk);
        #1;
        @(posedge clk); #1;
        req     = 4'b0000;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        @(negedge clk);
        chk("idle_after_timeout", busy, 1'b0);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
